// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall sequencing, control-flow flushes and
// saturating stall/flush statistics for the PC, IF/ID and ID/EX registers.
module hazard_stall_controller #(
   parameter int unsigned LOAD_STALL_CYCLES = 1  // bubbles per load-use hazard, 1..15
) (
   input  logic        clk_i,
   input  logic        reset_i,            // synchronous, active-high
   input  logic [31:0] id_instruction_i,
   input  logic [1:0]  ex_mem_read_i,
   input  logic [4:0]  ex_write_reg_i,
   input  logic        ex_branch_taken_i,
   input  logic        id_jump_i,
   input  logic        id_jump_return_i,
   output logic        pc_write_o,
   output logic        if_id_write_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        stall_state_o,
   output logic [31:0] stall_count_o,
   output logic [31:0] flush_count_o
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   // Cycles still to hold once the STALL state is entered (the RUN cycle that
   // detected the hazard already counts as the first one).
   localparam logic [3:0] RELOAD = 4'(LOAD_STALL_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  remaining_q, remaining_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   logic [4:0]  id_rs, id_rt;
   logic        haz;
   logic        unused_instr_bits;

   assign id_rs = id_instruction_i[25:21];
   assign id_rt = id_instruction_i[20:16];
   assign unused_instr_bits = ^{id_instruction_i[31:26], id_instruction_i[15:0]};

   // Load in EX writes a register that the instruction in ID reads.
   assign haz = (ex_mem_read_i != 2'b00) && (ex_write_reg_i != 5'd0) &&
                ((ex_write_reg_i == id_rs) || (ex_write_reg_i == id_rt));

   // Priority chain: reset, taken branch, ongoing stall, new hazard, jump, normal.
   always_comb begin
      // NOTE: every output and next-state signal gets a default first so no
      // path through the branches below can leave one unassigned (no latches).
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      state_d       = state_q;
      remaining_d   = remaining_q;

      if (reset_i) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         state_d       = ST_RUN;
         remaining_d   = 4'd0;
      end else if (ex_branch_taken_i) begin
         // Wrong-path squash; also aborts any stall in progress.
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         state_d       = ST_RUN;
         remaining_d   = 4'd0;
      end else if (state_q == ST_STALL) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         id_ex_flush_o = 1'b1;
         remaining_d   = remaining_q - 4'd1;
         if (remaining_q == 4'd1) begin
            state_d = ST_RUN;
         end
      end else if (haz) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         id_ex_flush_o = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            state_d     = ST_STALL;
            remaining_d = RELOAD;
         end
      end else if (id_jump_i || id_jump_return_i) begin
         // A jr waiting on a load lands here only after its stall has cleared.
         if_id_flush_o = 1'b1;
      end
   end

   // Saturating statistics: count held-PC cycles and flush cycles.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!pc_write_o && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      if ((if_id_flush_o || id_ex_flush_o) && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   // State, stall countdown and counters; reset sampled on the clock edge.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset_i) begin
         state_q       <= ST_RUN;
         remaining_q   <= 4'd0;
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_state_o = (state_q == ST_STALL);
   assign stall_count_o = stall_count_q;
   assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed testbench for hazard_stall_controller with LOAD_STALL_CYCLES = 1, 3, 4.
module tb_hazard_stall_controller;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic [1:0]  mem_read;
   logic [4:0]  wr_reg;
   logic        br_taken;
   logic        jump;
   logic        jump_ret;

   logic        pcw1, ifw1, iff1, exf1, ss1;
   logic [31:0] sc1, fc1;
   logic        pcw3, ifw3, iff3, exf3, ss3;
   logic [31:0] sc3, fc3;
   logic        pcw4, ifw4, iff4, exf4, ss4;
   logic [31:0] sc4, fc4;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   hazard_stall_controller #(.LOAD_STALL_CYCLES(1)) u1 (
      .clk_i(clk), .reset_i(reset), .id_instruction_i(instr),
      .ex_mem_read_i(mem_read), .ex_write_reg_i(wr_reg),
      .ex_branch_taken_i(br_taken), .id_jump_i(jump), .id_jump_return_i(jump_ret),
      .pc_write_o(pcw1), .if_id_write_o(ifw1), .if_id_flush_o(iff1),
      .id_ex_flush_o(exf1), .stall_state_o(ss1),
      .stall_count_o(sc1), .flush_count_o(fc1)
   );

   hazard_stall_controller #(.LOAD_STALL_CYCLES(3)) u3 (
      .clk_i(clk), .reset_i(reset), .id_instruction_i(instr),
      .ex_mem_read_i(mem_read), .ex_write_reg_i(wr_reg),
      .ex_branch_taken_i(br_taken), .id_jump_i(jump), .id_jump_return_i(jump_ret),
      .pc_write_o(pcw3), .if_id_write_o(ifw3), .if_id_flush_o(iff3),
      .id_ex_flush_o(exf3), .stall_state_o(ss3),
      .stall_count_o(sc3), .flush_count_o(fc3)
   );

   hazard_stall_controller #(.LOAD_STALL_CYCLES(4)) u4 (
      .clk_i(clk), .reset_i(reset), .id_instruction_i(instr),
      .ex_mem_read_i(mem_read), .ex_write_reg_i(wr_reg),
      .ex_branch_taken_i(br_taken), .id_jump_i(jump), .id_jump_return_i(jump_ret),
      .pc_write_o(pcw4), .if_id_write_o(ifw4), .if_id_flush_o(iff4),
      .id_ex_flush_o(exf4), .stall_state_o(ss4),
      .stall_count_o(sc4), .flush_count_o(fc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr    = 32'd0;
      mem_read = 2'b00;
      wr_reg   = 5'd0;
      br_taken = 1'b0;
      jump     = 1'b0;
      jump_ret = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
      return {6'd0, rs, rt, 16'd0};
   endfunction

   initial begin
      idle();
      reset = 1'b1;
      #1;

      // ---- reset behaviour ----
      check("rst_pcw",  {31'd0, pcw1}, 32'd0);
      check("rst_ifw",  {31'd0, ifw1}, 32'd0);
      check("rst_iff",  {31'd0, iff1}, 32'd1);
      check("rst_exf",  {31'd0, exf1}, 32'd1);
      step();
      step();
      reset = 1'b0;
      #1;
      check("rel_pcw",  {31'd0, pcw1}, 32'd1);
      check("rel_ifw",  {31'd0, ifw1}, 32'd1);
      check("rel_iff",  {31'd0, iff1}, 32'd0);
      check("rel_exf",  {31'd0, exf1}, 32'd0);
      check("rel_ss",   {31'd0, ss1},  32'd0);
      check("rel_sc",   sc1, 32'd0);
      check("rel_fc",   fc1, 32'd0);

      // ---- load-use, 1 bubble, hazard on rs = 8 ----
      instr = mk_instr(5'd8, 5'd0); mem_read = 2'b01; wr_reg = 5'd8;
      #1;
      check("n1_haz_pcw", {31'd0, pcw1}, 32'd0);
      check("n1_haz_exf", {31'd0, exf1}, 32'd1);
      check("n1_haz_iff", {31'd0, iff1}, 32'd0);
      check("n1_haz_ss",  {31'd0, ss1},  32'd0);
      step();
      mem_read = 2'b00; wr_reg = 5'd0;
      #1;
      check("n1_after_pcw", {31'd0, pcw1}, 32'd1);
      check("n1_after_exf", {31'd0, exf1}, 32'd0);
      check("n1_sc", sc1, 32'd1);
      check("n1_fc", fc1, 32'd1);
      // load writing r0 never creates a hazard
      instr = mk_instr(5'd0, 5'd0); mem_read = 2'b01; wr_reg = 5'd0;
      #1;
      check("n1_r0_pcw", {31'd0, pcw1}, 32'd1);
      check("n1_r0_exf", {31'd0, exf1}, 32'd0);
      step();
      idle();
      #1;
      check("n1_r0_sc", sc1, 32'd1);

      // ---- load-use, 3 bubbles, hazard on rt = 9 ----
      do_reset();
      instr = mk_instr(5'd0, 5'd9); mem_read = 2'b01; wr_reg = 5'd9;
      #1;
      check("n3_c0_pcw", {31'd0, pcw3}, 32'd0);
      check("n3_c0_ss",  {31'd0, ss3},  32'd0);
      step();
      mem_read = 2'b00;
      #1;
      check("n3_c1_pcw", {31'd0, pcw3}, 32'd0);
      check("n3_c1_ss",  {31'd0, ss3},  32'd1);
      check("n3_c1_exf", {31'd0, exf3}, 32'd1);
      step();
      check("n3_c2_pcw", {31'd0, pcw3}, 32'd0);
      check("n3_c2_ss",  {31'd0, ss3},  32'd1);
      step();
      check("n3_c3_pcw", {31'd0, pcw3}, 32'd1);
      check("n3_c3_ss",  {31'd0, ss3},  32'd0);
      check("n3_c3_exf", {31'd0, exf3}, 32'd0);
      check("n3_sc", sc3, 32'd3);
      check("n3_fc", fc3, 32'd3);

      // ---- taken branch aborts a 4-cycle stall on its 2nd cycle ----
      do_reset();
      instr = mk_instr(5'd12, 5'd0); mem_read = 2'b10; wr_reg = 5'd12;
      #1;
      check("n4_c0_pcw", {31'd0, pcw4}, 32'd0);
      step();
      mem_read = 2'b00;
      br_taken = 1'b1;
      #1;
      check("n4_br_ss",  {31'd0, ss4},  32'd1);
      check("n4_br_pcw", {31'd0, pcw4}, 32'd1);
      check("n4_br_iff", {31'd0, iff4}, 32'd1);
      check("n4_br_exf", {31'd0, exf4}, 32'd1);
      step();
      br_taken = 1'b0;
      #1;
      check("n4_post_ss",  {31'd0, ss4},  32'd0);
      check("n4_post_pcw", {31'd0, pcw4}, 32'd1);
      check("n4_post_iff", {31'd0, iff4}, 32'd0);
      check("n4_post_exf", {31'd0, exf4}, 32'd0);
      check("n4_sc", sc4, 32'd1);
      check("n4_fc", fc4, 32'd2);

      // ---- jr depending on a load into r31, then a plain jump ----
      do_reset();
      instr = mk_instr(5'd31, 5'd0); jump_ret = 1'b1; mem_read = 2'b01; wr_reg = 5'd31;
      #1;
      check("jr_stall_pcw", {31'd0, pcw1}, 32'd0);
      check("jr_stall_iff", {31'd0, iff1}, 32'd0);
      check("jr_stall_exf", {31'd0, exf1}, 32'd1);
      step();
      mem_read = 2'b00;
      #1;
      check("jr_flush_pcw", {31'd0, pcw1}, 32'd1);
      check("jr_flush_iff", {31'd0, iff1}, 32'd1);
      check("jr_flush_exf", {31'd0, exf1}, 32'd0);
      step();
      idle();
      jump = 1'b1;
      #1;
      check("j_iff", {31'd0, iff1}, 32'd1);
      check("j_exf", {31'd0, exf1}, 32'd0);
      check("j_pcw", {31'd0, pcw1}, 32'd1);
      step();
      idle();
      #1;
      check("j_sc", sc1, 32'd1);
      check("j_fc", fc1, 32'd3);

      // ---- FlushCount saturation ----
      force u1.flush_count_q = 32'hFFFF_FFFE;
      #1;
      release u1.flush_count_q;
      #1;
      check("sat_preload", fc1, 32'hFFFF_FFFE);
      br_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("sat_fc_%0d", i), fc1, 32'hFFFF_FFFF);
      end
      idle();
      step();
      check("sat_hold", fc1, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
